// File: rtl/snapshot_mem_responder.sv
// snapshot_mem_responder: register-file memory model behind the snapshot adapter's
// downstream req/ack interface. One access in flight; the ack arrives a fixed
// LATENCY cycles after acceptance. Out-of-range and read+write accesses are flagged
// with mem_err in the ack cycle.
`timescale 1ns/1ps

module snapshot_mem_responder #(
    parameter int MEM_DATA_WIDTH = 64,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int DEPTH          = 16,
    parameter int LATENCY        = 2,
    parameter logic [MEM_DATA_WIDTH-1:0] RST_VALUE = {MEM_DATA_WIDTH{1'b0}},
    parameter logic [MEM_DATA_WIDTH-1:0] ERR_VALUE = {MEM_DATA_WIDTH{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      soft_rst,
    input  logic                      mem_req_vld,
    output logic                      mem_ack_vld,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic                      mem_rd_en,
    input  logic                      mem_wr_en,
    input  logic [MEM_DATA_WIDTH-1:0] mem_wr_data,
    output logic [MEM_DATA_WIDTH-1:0] mem_rd_data,
    output logic                      mem_err
);

    localparam int IDX_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = (LATENCY <= 2) ? 1 : $clog2(LATENCY);
    // The counter holds the remaining S_BUSY cycles minus one, so it never exceeds LATENCY-2.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);
    localparam logic [MEM_ADDR_WIDTH-1:0] DEPTH_A = MEM_ADDR_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      gap_q, gap_d;
    logic                      ack_q, ack_d;
    logic                      err_q, err_d;
    logic [MEM_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [MEM_DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                      pend_rd_q, pend_rd_d;
    logic                      pend_err_q, pend_err_d;

    logic [MEM_DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]          idx;
    logic                      in_range;
    logic                      is_rd;
    logic                      bad;
    logic                      accept;
    logic                      wr_commit;
    logic [MEM_DATA_WIDTH-1:0] rd_word;

    // Request decode: soft_rst suppresses acceptance so an aborted write never lands.
    always_comb begin
        idx       = mem_addr[IDX_W-1:0];
        in_range  = (mem_addr < DEPTH_A);
        is_rd     = mem_rd_en & ~mem_wr_en;
        bad       = ~in_range | (mem_rd_en & mem_wr_en);
        accept    = (state_q == S_IDLE) & mem_req_vld & (mem_rd_en | mem_wr_en)
                    & ~gap_q & ~soft_rst;
        wr_commit = accept & mem_wr_en & in_range;
        rd_word   = in_range ? mem_q[idx] : ERR_VALUE;
    end

    // Next-state logic for the FSM, the latency counter and the registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_data_d = pend_data_q;
        pend_rd_d   = pend_rd_q;
        pend_err_d  = pend_err_q;
        rd_data_d   = rd_data_q;
        gap_d       = (state_q == S_ACK);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pend_data_d = rd_word;
                    pend_rd_d   = is_rd;
                    pend_err_d  = bad;
                    if (LATENCY == 1) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (soft_rst) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end

        // Read data is only refreshed on the edge entering S_ACK of a read access.
        if ((state_d == S_ACK) && (state_q != S_ACK) && pend_rd_d) begin
            rd_data_d = pend_data_d;
        end

        ack_d = (state_d == S_ACK);
        err_d = (state_d == S_ACK) & pend_err_d;
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gap_q       <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            pend_data_q <= '0;
            pend_rd_q   <= 1'b0;
            pend_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            pend_data_q <= pend_data_d;
            pend_rd_q   <= pend_rd_d;
            pend_err_q  <= pend_err_d;
        end
    end

    // Register-file array: reloaded on rst, written at the acceptance edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VALUE;
            end
        end else if (wr_commit) begin
            mem_q[idx] <= mem_wr_data;
        end
    end

    assign mem_ack_vld = ack_q;
    assign mem_err     = err_q;
    assign mem_rd_data = rd_data_q;

endmodule
